counter_dev_io: RTL and testbench
=================================

# counter_dev_io

Three-channel 32-bit down-counter peripheral on the CPU I/O bus. It sits directly downstream of the GPIO/LED register, which owns the 2-bit `counter_set` selector. The CPU first writes `counter_set` through the GPIO register. It then writes the counter address, and this block routes the data word to the channel or control register that `counter_set` selects. Each channel counts on its own tick enable and drives a terminal output used for interrupts and timing.

## Interface
- `CW`, default 32: counter and reload register width.
- `clk` input 1: system clock. All state updates on the falling edge of `clk`, matching the other I/O devices.
- `reset` input 1: synchronous, active-high, sampled on the falling edge of `clk`.
- `counter_we` input 1: CPU write strobe for the counter address.
- `counter_set` input 2: register select from the GPIO register.
  - 00, 01, 10: channel 0, 1, 2.
  - 11: control register.
- `counter_val` input CW: write data from the CPU bus.
- `cnt_en` input 3: per-channel count tick, one `clk` wide, from the clock divider. Bit n serves channel n.
- `counter_out` output CW: readback of the selected register.
  - 00, 01, 10: current count of channel 0, 1, 2.
  - 11: `{26'b0, ctrl[5:0]}`.
- `counter0_out`, `counter1_out`, `counter2_out` output 1: channel terminal outputs.

## Operation
- Per channel n: `count_n` (CW), `reload_n` (CW), `out_n` (1). Shared: `ctrl[5:0]`, where `mode_n = ctrl[2n+1:2n]`.
- Modes:
  - 00 one-shot: decrement on tick while `count != 0`. On the tick that takes the count from 1 to 0, set `out_n` = 1 and hold it until the next channel write. `count` stays at 0.
  - 01 periodic: on a tick with `count == 1`, load `count <= reload` and pulse `out_n` high for exactly one `clk`. Other ticks decrement.
  - 10 square: same reload behaviour as periodic, but `out_n` toggles at each reload instead of pulsing.
  - 11 hold: count frozen, `out_n` frozen.
- Channel write (`counter_we`=1, `counter_set`=n): `count_n <= counter_val`, `reload_n <= counter_val`, `out_n <= 0`.
- Control write (`counter_set`=11): `ctrl <= counter_val[5:0]`. All `out_n` cleared. Counts and reloads are preserved.
- Zero value in periodic or square mode (`count == 0`, or reload 0): channel idles, `out_n` = 0, no decrement.
- Counts never underflow. No wrap below 0 in any mode.
- `counter_out` is a combinational mux of registered state selected by the live `counter_set`.

## Timing
- Reset values:
  - all counts 0, all reloads 0, `ctrl` = 6'b000000 (all one-shot, idle);
  - all `out_n` = 0;
  - `counter_out` = 0 for every `counter_set`.
- Write latency: registers update at the falling edge where `counter_we`=1. The new value is visible on `counter_out` immediately after that edge.
- Tick latency: a tick sampled at falling edge k updates the count and `out_n` at edge k. The periodic-mode pulse is high from edge k to edge k+1.
- Write and tick to the same channel on the same edge: the write wins and the tick is dropped.
- Write to channel n and tick on channel m≠n: both take effect.
- Control write and tick on the same edge:
  - the tick is processed under the old mode;
  - outputs then clear, with the control-write clear taking priority over any set or toggle on that edge.
- Reset asserted mid-count, including while a pulse is high: every register returns to its reset value at that edge. `cnt_en` and `counter_we` are ignored while `reset` = 1.
- `cnt_en` high for consecutive cycles counts once per cycle. No edge detection.

## Test plan
- Reset, then read all four `counter_set` values → `counter_out` = 0 each time; all three outputs 0.
- One-shot on channel 0:
  - stimulus: write 3 to channel 0, then 3 ticks;
  - response: counts read 2, 1, 0; `counter0_out` rises on the third tick and stays 1 through 5 further ticks;
  - rewrite 3 → `counter0_out` = 0.
- Periodic on channel 1:
  - stimulus: ctrl = 6'b000100, write 2 to channel 1, 6 ticks;
  - response: `counter1_out` one-clk pulse on ticks 2, 4, 6; count sequence 1, 2, 1, 2, 1, 2.
- Square on channel 2:
  - stimulus: ctrl = 6'b100000, write 1 to channel 2, 4 ticks;
  - response: `counter2_out` = 1, 0, 1, 0.
- Collision:
  - channel-1 write of 10 coincident with a channel-1 tick (count 5) → count = 10;
  - same edge, channel-0 tick → channel 0 decrements.
- Reset mid-run: periodic channel mid-pulse, then `reset` for one edge → all counts, ctrl and outputs 0. Ticks after reset leave the counts at 0.

Source files
------------

// File: rtl/counter_dev_io.sv
// counter_dev_io: three-channel down-counter peripheral on the CPU I/O bus.
//
// State changes on the falling edge of clk, in step with the other I/O
// devices on the bus. The CPU first selects a register through the GPIO
// register's counter_set field. It then writes the counter address. Each
// channel decrements on its own one-clk tick and drives a terminal output.
//
// Ports:
//   clk                      system clock (falling edge active)
//   reset                    synchronous active-high reset
//   counter_we               CPU write strobe for the counter address
//   counter_set[1:0]         register select: 0..2 channel, 3 control
//   counter_val[CW-1:0]      CPU write data
//   cnt_en[2:0]              per-channel count tick, bit n -> channel n
//   counter_out[CW-1:0]      readback of the register selected by counter_set
//   counter0/1/2_out         channel terminal outputs
module counter_dev_io #(
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          counter_we,
    input  logic [1:0]    counter_set,
    input  logic [CW-1:0] counter_val,
    input  logic [2:0]    cnt_en,
    output logic [CW-1:0] counter_out,
    output logic          counter0_out,
    output logic          counter1_out,
    output logic          counter2_out
);

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_SQUARE   = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    logic [CW-1:0] count_q  [3];
    logic [CW-1:0] count_d  [3];
    logic [CW-1:0] reload_q [3];
    logic [CW-1:0] reload_d [3];
    logic [2:0]    out_q, out_d;
    logic [5:0]    ctrl_q, ctrl_d;

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        out_d    = out_q;
        ctrl_d   = ctrl_q;

        for (int unsigned n = 0; n < 3; n++) begin
            // Ticks are evaluated under the mode in force before this edge.
            // A same-edge control write is applied afterwards.
            case (mode_e'(ctrl_q[2*n +: 2]))
                MODE_ONESHOT: begin
                    if (cnt_en[n] && count_q[n] != '0) begin
                        count_d[n] = count_q[n] - CW'(1);
                        if (count_q[n] == CW'(1))
                            out_d[n] = 1'b1;
                    end
                end
                MODE_PERIODIC: begin
                    // Pulse lasts a single clk. It is cleared unless this
                    // edge reloads the channel.
                    out_d[n] = 1'b0;
                    if (cnt_en[n] && count_q[n] != '0 && reload_q[n] != '0) begin
                        if (count_q[n] == CW'(1)) begin
                            count_d[n] = reload_q[n];
                            out_d[n]   = 1'b1;
                        end else begin
                            count_d[n] = count_q[n] - CW'(1);
                        end
                    end
                end
                MODE_SQUARE: begin
                    if (count_q[n] == '0 || reload_q[n] == '0) begin
                        out_d[n] = 1'b0;
                    end else if (cnt_en[n]) begin
                        if (count_q[n] == CW'(1)) begin
                            count_d[n] = reload_q[n];
                            out_d[n]   = ~out_q[n];
                        end else begin
                            count_d[n] = count_q[n] - CW'(1);
                        end
                    end
                end
                default: ; // hold: count and output frozen
            endcase

            // A write to this channel overrides any tick on the same edge.
            if (counter_we && counter_set == 2'(n)) begin
                count_d[n]  = counter_val;
                reload_d[n] = counter_val;
                out_d[n]    = 1'b0;
            end
        end

        if (counter_we && counter_set == 2'd3) begin
            ctrl_d = counter_val[5:0];
            out_d  = '0;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            for (int unsigned n = 0; n < 3; n++) begin
                count_q[n]  <= '0;
                reload_q[n] <= '0;
            end
            out_q  <= '0;
            ctrl_q <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            out_q    <= out_d;
            ctrl_q   <= ctrl_d;
        end
    end

    always_comb begin
        case (counter_set)
            2'd0:    counter_out = count_q[0];
            2'd1:    counter_out = count_q[1];
            2'd2:    counter_out = count_q[2];
            default: counter_out = {{(CW-6){1'b0}}, ctrl_q};
        endcase
    end

    assign counter0_out = out_q[0];
    assign counter1_out = out_q[1];
    assign counter2_out = out_q[2];

endmodule

// File: tb/tb_counter_dev_io.sv
module tb_counter_dev_io;

    logic        clk;
    logic        reset;
    logic        counter_we;
    logic [1:0]  counter_set;
    logic [31:0] counter_val;
    logic [2:0]  cnt_en;
    logic [31:0] counter_out;
    logic        counter0_out, counter1_out, counter2_out;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    counter_dev_io #(.CW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .counter_we   (counter_we),
        .counter_set  (counter_set),
        .counter_val  (counter_val),
        .cnt_en       (cnt_en),
        .counter_out  (counter_out),
        .counter0_out (counter0_out),
        .counter1_out (counter1_out),
        .counter2_out (counter2_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: register file updated at each falling edge from the
    // behavioural rules of the peripheral.
    logic [31:0] m_cnt [3];
    logic [31:0] m_rld [3];
    logic        m_o   [3];
    logic [5:0]  m_ctl;

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_rld[i] = 0; m_o[i] = 0;
        end
        m_ctl = 0;
    end

    always @(negedge clk) begin
        int mode;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0; m_rld[i] = 0; m_o[i] = 0;
            end
            m_ctl = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                mode = (int'(m_ctl) >> (2*i)) & 3;
                if (counter_we && int'(counter_set) == i) begin
                    m_cnt[i] = counter_val;
                    m_rld[i] = counter_val;
                    m_o[i]   = 0;
                end else if (mode == 0) begin
                    if (cnt_en[i] && m_cnt[i] > 0) begin
                        m_cnt[i] = m_cnt[i] - 1;
                        if (m_cnt[i] == 0) m_o[i] = 1;
                    end
                end else if (mode == 1 || mode == 2) begin
                    if (m_cnt[i] == 0 || m_rld[i] == 0) begin
                        m_o[i] = 0;
                    end else begin
                        if (mode == 1) m_o[i] = 0;
                        if (cnt_en[i]) begin
                            if (m_cnt[i] == 1) begin
                                m_cnt[i] = m_rld[i];
                                m_o[i]   = (mode == 1) ? 1'b1 : !m_o[i];
                            end else begin
                                m_cnt[i] = m_cnt[i] - 1;
                            end
                        end
                    end
                end
            end
            if (counter_we && counter_set == 2'd3) begin
                m_ctl = counter_val[5:0];
                for (int i = 0; i < 3; i++) m_o[i] = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model, away from the active (falling) edge.
    always @(posedge clk) begin
        logic [31:0] exp_out;
        if (chk_on) begin
            exp_out = (counter_set == 2'd3) ? {26'b0, m_ctl} : m_cnt[counter_set];
            chk("model_counter_out", counter_out, exp_out);
            chk("model_out0", {31'b0, counter0_out}, {31'b0, m_o[0]});
            chk("model_out1", {31'b0, counter1_out}, {31'b0, m_o[1]});
            chk("model_out2", {31'b0, counter2_out}, {31'b0, m_o[2]});
        end
    end

    // Drives one falling edge worth of inputs, then returns with strobes idle.
    task automatic step(input logic rst, input logic we, input logic [1:0] set,
                        input logic [31:0] val, input logic [2:0] en);
        reset = rst; counter_we = we; counter_set = set; counter_val = val; cnt_en = en;
        @(posedge clk); #1;
        reset = 0; counter_we = 0; cnt_en = 0;
    endtask

    task automatic rd(input logic [1:0] s, output logic [31:0] v);
        counter_set = s; #1; v = counter_out;
    endtask

    logic [31:0] v;

    initial begin
        reset = 1; counter_we = 0; counter_set = 0; counter_val = 0; cnt_en = 0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0);
        chk_on = 1;

        // Reset state
        for (int s = 0; s < 4; s++) begin
            rd(2'(s), v); chk("reset_read", v, 0);
        end
        chk("reset_outs", {29'b0, counter2_out, counter1_out, counter0_out}, 0);

        // One-shot channel 0
        step(0, 1, 0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 3'b001);
            rd(0, v); chk("oneshot_cnt", v, 32'(2 - i));
            chk("oneshot_out", {31'b0, counter0_out}, (i == 2) ? 1 : 0);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 3'b001);
            chk("oneshot_hold", {31'b0, counter0_out}, 1);
            rd(0, v); chk("oneshot_zero", v, 0);
        end
        step(0, 1, 0, 3, 0);
        chk("oneshot_rewrite", {31'b0, counter0_out}, 0);

        // Periodic channel 1
        step(0, 1, 3, 32'h04, 0);
        rd(3, v); chk("ctrl_read", v, 32'h04);
        step(0, 1, 1, 2, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 0, 3'b010);
            rd(1, v); chk("periodic_cnt", v, (i % 2 == 0) ? 1 : 2);
            chk("periodic_out", {31'b0, counter1_out}, (i % 2 == 1) ? 1 : 0);
        end
        step(0, 0, 1, 0, 0);
        chk("periodic_pulse_end", {31'b0, counter1_out}, 0);

        // Square channel 2
        step(0, 1, 3, 32'h20, 0);
        step(0, 1, 2, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 2, 0, 3'b100);
            chk("square_out", {31'b0, counter2_out}, (i % 2 == 0) ? 1 : 0);
        end

        // Write/tick collision
        step(0, 1, 3, 0, 0);
        step(0, 1, 1, 5, 0);
        step(0, 1, 0, 4, 0);
        step(0, 1, 1, 10, 3'b011);
        rd(1, v); chk("collide_write_wins", v, 10);
        rd(0, v); chk("collide_other_ticks", v, 3);

        // Reset mid-pulse
        step(0, 1, 3, 32'h04, 0);
        step(0, 1, 1, 2, 0);
        step(0, 0, 1, 0, 3'b010);
        step(0, 0, 1, 0, 3'b010);
        chk("midpulse_high", {31'b0, counter1_out}, 1);
        step(1, 1, 0, 9, 3'b111);
        for (int s = 0; s < 4; s++) begin
            rd(2'(s), v); chk("midreset_read", v, 0);
        end
        chk("midreset_outs", {29'b0, counter2_out, counter1_out, counter0_out}, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3'b111);
        for (int s = 0; s < 3; s++) begin
            rd(2'(s), v); chk("postreset_ticks", v, 0);
        end

        // Randomized traffic checked by the model
        for (int i = 0; i < 2000; i++) begin
            logic        r, w;
            logic [1:0]  s;
            logic [31:0] d;
            r = ($urandom_range(0, 199) == 0);
            w = ($urandom_range(0, 5) == 0);
            s = 2'($urandom_range(0, 3));
            d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 5));
            if (s == 2'd3) d = $urandom;
            step(r, w, s, d, 3'($urandom_range(0, 7)));
            counter_set = 2'($urandom_range(0, 3));
        end

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
